// File: rtl/testcore_nios2_gen2_f_oci_pkg.sv
// +----------------------------------------------------------------------------+
// | testcore_nios2_gen2_f_oci_pkg                                              |
// | Shared constants for the OCI trace DCT packer. Optional macro:             |
// | NIOS2_OCI_DCT_TIMESTAMP_EN widens address payloads by a 16-bit timestamp.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package testcore_nios2_gen2_f_oci_pkg;
  localparam int DCT_BUF_W = 30;
  localparam int DCT_CNT_W = 4;

  localparam logic [1:0] TAKEN     = 2'b01;
  localparam logic [1:0] NOT_TAKEN = 2'b10;

  localparam logic FRM_DCT  = 1'b0;
  localparam logic FRM_ADDR = 1'b1;

  localparam logic [1:0] ST_ACC       = 2'd0;
  localparam logic [1:0] ST_EMIT_DCT  = 2'd1;
  localparam logic [1:0] ST_EMIT_ADDR = 2'd2;

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  localparam int TS_W = 16;
`else
  localparam int TS_W = 0;
`endif

  function automatic logic is_legal_code(input logic [1:0] code);
    return (code == TAKEN) || (code == NOT_TAKEN);
  endfunction
endpackage

`default_nettype wire

// File: rtl/testcore_nios2_gen2_f_oci_dct_packer_if.sv
// +----------------------------------------------------------------------------+
// | testcore_nios2_gen2_f_oci_dct_packer_if                                    |
// | Frame bus from the DCT packer to the trace FIFO (valid/ready handshake).   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

interface testcore_nios2_gen2_f_oci_dct_packer_if #(
  parameter int ADDR_W = 32
);
  import testcore_nios2_gen2_f_oci_pkg::*;

  localparam int FRM_ADDR_W = ADDR_W + TS_W;

  logic                  frm_valid;
  logic                  frm_ready;
  logic                  frm_type;
  logic [DCT_BUF_W-1:0]  frm_dct_buffer;
  logic [DCT_CNT_W-1:0]  frm_dct_count;
  logic [FRM_ADDR_W-1:0] frm_addr;

  modport master (
    output frm_valid, frm_type, frm_dct_buffer, frm_dct_count, frm_addr,
    input  frm_ready
  );

  modport slave (
    input  frm_valid, frm_type, frm_dct_buffer, frm_dct_count, frm_addr,
    output frm_ready
  );
endinterface

`default_nettype wire

// File: rtl/testcore_nios2_gen2_f_oci_dct_frame_reg.sv
// +----------------------------------------------------------------------------+
// | testcore_nios2_gen2_f_oci_dct_frame_reg                                    |
// | One-entry valid/ready output register holding a frame until accepted.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module testcore_nios2_gen2_f_oci_dct_frame_reg
  import testcore_nios2_gen2_f_oci_pkg::*;
#(
  parameter int PAY_W = 32
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  i_load,
  input  wire                  i_type,
  input  wire [DCT_BUF_W-1:0]  i_buffer,
  input  wire [DCT_CNT_W-1:0]  i_count,
  input  wire [PAY_W-1:0]      i_addr,
  input  wire                  i_ready,
  output logic                 o_valid,
  output logic                 o_type,
  output logic [DCT_BUF_W-1:0] o_buffer,
  output logic [DCT_CNT_W-1:0] o_count,
  output logic [PAY_W-1:0]     o_addr
);
  logic                 valid_q, valid_d;
  logic                 type_q, type_d;
  logic [DCT_BUF_W-1:0] buffer_q, buffer_d;
  logic [DCT_CNT_W-1:0] count_q, count_d;
  logic [PAY_W-1:0]     addr_q, addr_d;

  // A load on the handshake edge keeps valid high with the new payload.
  always_comb begin
    valid_d  = valid_q;
    type_d   = type_q;
    buffer_d = buffer_q;
    count_d  = count_q;
    addr_d   = addr_q;
    if (i_load) begin
      valid_d  = 1'b1;
      type_d   = i_type;
      buffer_d = i_buffer;
      count_d  = i_count;
      addr_d   = i_addr;
    end else if (valid_q && i_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      type_q   <= 1'b0;
      buffer_q <= '0;
      count_q  <= '0;
      addr_q   <= '0;
    end else begin
      valid_q  <= valid_d;
      type_q   <= type_d;
      buffer_q <= buffer_d;
      count_q  <= count_d;
      addr_q   <= addr_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_type   = type_q;
  assign o_buffer = buffer_q;
  assign o_count  = count_q;
  assign o_addr   = addr_q;
endmodule

`default_nettype wire

// File: rtl/testcore_nios2_gen2_f_oci_dct_packer.sv
// +----------------------------------------------------------------------------+
// | testcore_nios2_gen2_f_oci_dct_packer                                       |
// | Packs 2-bit branch codes into DCT frames and emits DCT/address frames.     |
// | Optional macro: NIOS2_OCI_DCT_TIMESTAMP_EN (timestamp in address frames).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module testcore_nios2_gen2_f_oci_dct_packer
  import testcore_nios2_gen2_f_oci_pkg::*;
#(
  parameter int DCT_DEPTH = 15,
  parameter int ADDR_W    = 32
) (
  input  wire                  clk,
  input  wire                  reset,
  input  wire                  trc_on,
  input  wire                  cti_valid,
  input  wire [1:0]            cti_code,
  input  wire                  ind_valid,
  input  wire [ADDR_W-1:0]     ind_addr,
  input  wire                  flush,
  testcore_nios2_gen2_f_oci_dct_packer_if.master frm,
  output logic [DCT_BUF_W-1:0] dct_buffer,
  output logic [DCT_CNT_W-1:0] dct_count,
  output logic                 overflow
);
  localparam int                   PAY_W   = ADDR_W + TS_W;
  localparam logic [DCT_CNT_W-1:0] DEPTH_C = DCT_CNT_W'(DCT_DEPTH);

  logic [1:0]           state_q, state_d;
  logic [DCT_BUF_W-1:0] acc_buf_q, acc_buf_d, acc_buf_pk;
  logic [DCT_CNT_W-1:0] acc_cnt_q, acc_cnt_d, acc_cnt_pk;
  logic                 hold_valid_q, hold_valid_d;
  logic [PAY_W-1:0]     hold_q, hold_d, ind_payload;
  logic                 overflow_q, overflow_d;

  logic                 frm_hs, cti_ok, stalled, cti_acc, ind_ev, addr_pend;
  logic                 ld, ld_type, live_clr, hold_take, ind_direct, ind_drop;
  logic [DCT_BUF_W-1:0] ld_buf;
  logic [DCT_CNT_W-1:0] ld_cnt;
  logic [PAY_W-1:0]     ld_pay;

`ifdef NIOS2_OCI_DCT_TIMESTAMP_EN
  logic [15:0] ts_q, ts_d;
  assign ts_d        = ts_q + 16'd1;
  assign ind_payload = {ts_q, ind_addr};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) ts_q <= '0;
    else       ts_q <= ts_d;
  end
`else
  assign ind_payload = ind_addr;
`endif

  assign frm_hs     = frm.frm_valid & frm.frm_ready;
  assign cti_ok     = trc_on & cti_valid & is_legal_code(cti_code);
  assign stalled    = (acc_cnt_q == DEPTH_C);
  assign cti_acc    = cti_ok & ~stalled;
  assign ind_ev     = trc_on & ind_valid;
  assign addr_pend  = hold_valid_q | ind_ev;
  // The same-cycle code is packed before any frame decision is taken.
  assign acc_buf_pk = cti_acc ? {acc_buf_q[DCT_BUF_W-3:0], cti_code} : acc_buf_q;
  assign acc_cnt_pk = acc_cnt_q + DCT_CNT_W'(cti_acc);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_ACC;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_ACC: begin
        if ((acc_cnt_pk == DEPTH_C) ||
            ((acc_cnt_pk != '0) && (flush || addr_pend)))
          state_d = ST_EMIT_DCT;
        else if (addr_pend)
          state_d = ST_EMIT_ADDR;
      end
      // Codes gathered after the emitted frame must go out before the address.
      ST_EMIT_DCT:  if (frm_hs) state_d = (hold_valid_q && acc_cnt_pk == '0) ? ST_EMIT_ADDR : ST_ACC;
      ST_EMIT_ADDR: if (frm_hs) state_d = ST_ACC;
      default:      state_d = ST_ACC;
    endcase
  end

  always_comb begin
    ld         = 1'b0;
    ld_type    = FRM_DCT;
    ld_buf     = acc_buf_pk;
    ld_cnt     = acc_cnt_pk;
    ld_pay     = '0;
    live_clr   = 1'b0;
    hold_take  = 1'b0;
    ind_direct = 1'b0;
    if (state_q != ST_EMIT_DCT && state_d == ST_EMIT_DCT) begin
      ld       = 1'b1;
      live_clr = 1'b1;
    end else if (state_q != ST_EMIT_ADDR && state_d == ST_EMIT_ADDR) begin
      ld         = 1'b1;
      ld_type    = FRM_ADDR;
      ld_buf     = '0;
      ld_cnt     = '0;
      ld_pay     = hold_valid_q ? hold_q : ind_payload;
      hold_take  = hold_valid_q;
      ind_direct = ~hold_valid_q;
    end
  end

  assign ind_drop = ind_ev & hold_valid_q & ~hold_take;

  always_comb begin
    hold_valid_d = hold_valid_q & ~hold_take;
    hold_d       = hold_q;
    if (ind_ev && !ind_direct && (!hold_valid_q || hold_take)) begin
      hold_valid_d = 1'b1;
      hold_d       = ind_payload;
    end
    acc_buf_d  = live_clr ? '0 : acc_buf_pk;
    acc_cnt_d  = live_clr ? '0 : acc_cnt_pk;
    overflow_d = overflow_q | (cti_ok & stalled) | ind_drop;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_buf_q    <= '0;
      acc_cnt_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_q       <= '0;
      overflow_q   <= 1'b0;
    end else begin
      acc_buf_q    <= acc_buf_d;
      acc_cnt_q    <= acc_cnt_d;
      hold_valid_q <= hold_valid_d;
      hold_q       <= hold_d;
      overflow_q   <= overflow_d;
    end
  end

  testcore_nios2_gen2_f_oci_dct_frame_reg #(
    .PAY_W (PAY_W)
  ) u_frame_reg (
    .clk      (clk),
    .reset    (reset),
    .i_load   (ld),
    .i_type   (ld_type),
    .i_buffer (ld_buf),
    .i_count  (ld_cnt),
    .i_addr   (ld_pay),
    .i_ready  (frm.frm_ready),
    .o_valid  (frm.frm_valid),
    .o_type   (frm.frm_type),
    .o_buffer (frm.frm_dct_buffer),
    .o_count  (frm.frm_dct_count),
    .o_addr   (frm.frm_addr)
  );

  assign dct_buffer = acc_buf_q;
  assign dct_count  = acc_cnt_q;
  assign overflow   = overflow_q;
endmodule

`default_nettype wire

// File: tb/tb_testcore_nios2_gen2_f_oci_dct_packer.sv
// +----------------------------------------------------------------------------+
// | tb_testcore_nios2_gen2_f_oci_dct_packer                                    |
// | Scoreboard bench for the DCT packer frame stream and live accumulator.     |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_testcore_nios2_gen2_f_oci_dct_packer;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        trc_on = 1'b1;
  logic        cti_valid = 1'b0;
  logic [1:0]  cti_code = 2'b00;
  logic        ind_valid = 1'b0;
  logic [31:0] ind_addr = '0;
  logic        flush = 1'b0;
  logic [29:0] dct_buffer;
  logic [3:0]  dct_count;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic        t;
    logic [29:0] b;
    logic [3:0]  c;
    logic [31:0] a;
  } frame_t;
  frame_t sb[$];

  testcore_nios2_gen2_f_oci_dct_packer_if #(.ADDR_W(32)) frm_if ();

  testcore_nios2_gen2_f_oci_dct_packer #(
    .DCT_DEPTH (15),
    .ADDR_W    (32)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .trc_on     (trc_on),
    .cti_valid  (cti_valid),
    .cti_code   (cti_code),
    .ind_valid  (ind_valid),
    .ind_addr   (ind_addr),
    .flush      (flush),
    .frm        (frm_if),
    .dct_buffer (dct_buffer),
    .dct_count  (dct_count),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic frame_t dct_frm(input logic [29:0] b, input logic [3:0] c);
    frame_t f;
    f.t = 1'b0; f.b = b; f.c = c; f.a = '0;
    return f;
  endfunction

  function automatic frame_t addr_frm(input logic [31:0] a);
    frame_t f;
    f.t = 1'b1; f.b = '0; f.c = '0; f.a = a;
    return f;
  endfunction

  // Handshakes complete on the next rising edge; pop the expected frame now.
  always @(negedge clk) begin
    if (!reset && frm_if.frm_valid && frm_if.frm_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_frame", 64'(frm_if.frm_valid), 64'd0);
      end else begin
        frame_t e;
        e = sb.pop_front();
        chk("frm_type", 64'(frm_if.frm_type), 64'(e.t));
        chk("frm_dct_buffer", 64'(frm_if.frm_dct_buffer), 64'(e.b));
        chk("frm_dct_count", 64'(frm_if.frm_dct_count), 64'(e.c));
        if (e.t) chk("frm_addr", 64'(frm_if.frm_addr[31:0]), 64'(e.a));
      end
    end
  end

  task automatic drive(input logic cv, input logic [1:0] cc, input logic iv,
                       input logic [31:0] ia, input logic fl);
    cti_valid = cv; cti_code = cc; ind_valid = iv; ind_addr = ia; flush = fl;
    @(posedge clk); #1;
    cti_valid = 1'b0; ind_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((sb.size() != 0 || frm_if.frm_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    frm_if.frm_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_frm_valid", 64'(frm_if.frm_valid), 64'd0);
    chk("rst_frm_type", 64'(frm_if.frm_type), 64'd0);
    chk("rst_dct_count", 64'(dct_count), 64'd0);
    chk("rst_dct_buffer", 64'(dct_buffer), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    reset = 1'b0;

    // 15 taken codes fill a frame; live accumulator clears on the emit edge.
    sb.push_back(dct_frm(30'h1555_5555, 4'd15));
    for (int i = 0; i < 14; i++) drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    chk("t1_count14", 64'(dct_count), 64'd14);
    chk("t1_buf14", 64'(dct_buffer), 64'h555_5555);
    drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    chk("t1_live_clear", 64'(dct_count), 64'd0);
    chk("t1_frm_valid", 64'(frm_if.frm_valid), 64'd1);
    drain("t1_drain");

    // Codes then an indirect transfer: DCT frame, then address frame.
    sb.push_back(dct_frm(30'h19, 4'd3));
    sb.push_back(addr_frm(32'h0000_1040));
    drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b1, 2'b10, 1'b0, '0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b0, 2'b00, 1'b1, 32'h0000_1040, 1'b0);
    drain("t2_drain");

    // Backpressure: 35 codes -> 15 framed, 15 live, 5 dropped.
    frm_if.frm_ready = 1'b0;
    sb.push_back(dct_frm(30'h1555_5555, 4'd15));
    sb.push_back(dct_frm(30'h1555_5555, 4'd15));
    for (int i = 0; i < 20; i++) drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    chk("t3_mid_count", 64'(dct_count), 64'd5);
    chk("t3_mid_overflow", 64'(overflow), 64'd0);
    for (int i = 0; i < 15; i++) drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    idle(5);
    chk("t3_held_valid", 64'(frm_if.frm_valid), 64'd1);
    chk("t3_held_buf", 64'(frm_if.frm_dct_buffer), 64'h1555_5555);
    chk("t3_held_count", 64'(frm_if.frm_dct_count), 64'd15);
    chk("t3_live_count", 64'(dct_count), 64'd15);
    chk("t3_live_buf", 64'(dct_buffer), 64'h1555_5555);
    chk("t3_overflow", 64'(overflow), 64'd1);
    frm_if.frm_ready = 1'b1;
    drain("t3_drain");
    chk("t3_overflow_sticky", 64'(overflow), 64'd1);
    chk("t3_live_empty", 64'(dct_count), 64'd0);

    // Ignored events: illegal codes and trace disabled.
    drive(1'b1, 2'b00, 1'b0, '0, 1'b0);
    drive(1'b1, 2'b11, 1'b0, '0, 1'b0);
    trc_on = 1'b0;
    drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    trc_on = 1'b1;
    chk("t4_ignored_count", 64'(dct_count), 64'd0);

    // Flush with nothing pending emits nothing; partial flush emits 2 codes.
    drive(1'b0, 2'b00, 1'b0, '0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      chk("t4_flush0_valid", 64'(frm_if.frm_valid), 64'd0);
      idle(1);
    end
    sb.push_back(dct_frm(30'h5, 4'd2));
    drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b1, 2'b01, 1'b0, '0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, '0, 1'b1);
    drain("t4_drain");

    // Same-cycle code and indirect transfer: code lands in the DCT frame.
    sb.push_back(dct_frm(30'h1, 4'd1));
    sb.push_back(addr_frm(32'h0000_2000));
    drive(1'b1, 2'b01, 1'b1, 32'h0000_2000, 1'b0);
    drain("t5_drain");
    // Indirect transfer with an empty buffer goes straight to an address frame.
    sb.push_back(addr_frm(32'hDEAD_BEE0));
    drive(1'b0, 2'b00, 1'b1, 32'hDEAD_BEE0, 1'b0);
    drain("t5_addr_only");

    // Reset while a frame is held discards it.
    frm_if.frm_ready = 1'b0;
    drive(1'b1, 2'b10, 1'b0, '0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, '0, 1'b1);
    chk("t6_pre_valid", 64'(frm_if.frm_valid), 64'd1);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    chk("t6_rst_valid", 64'(frm_if.frm_valid), 64'd0);
    chk("t6_rst_buf", 64'(frm_if.frm_dct_buffer), 64'd0);
    chk("t6_rst_count", 64'(frm_if.frm_dct_count), 64'd0);
    chk("t6_rst_overflow", 64'(overflow), 64'd0);
    chk("t6_rst_live", 64'(dct_count), 64'd0);
    reset = 1'b0;
    frm_if.frm_ready = 1'b1;
    sb.push_back(dct_frm(30'h2, 4'd1));
    drive(1'b1, 2'b10, 1'b0, '0, 1'b0);
    drive(1'b0, 2'b00, 1'b0, '0, 1'b1);
    drain("t6_recover");

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
